// File: rtl/mont_mult_param_pkg.sv
// mont_mult_param_pkg: FSM states and word-count helper shared by the Montgomery multiplier.
package mont_mult_param_pkg;

    typedef enum logic [2:0] {IDLE, ADD_B, ADD_M, SHIFT, SUB, SELECT} state_t;

    function automatic int calc_k(input int n, input int w);
        return (n + 1 + w) / w;
    endfunction

endpackage

// File: rtl/mp_addsub_word.sv
// mp_addsub_word: W-bit adder slice with carry in/out; sub inverts the b operand.
module mp_addsub_word #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mont_mult_param.sv
// mont_mult_param: word-serial radix-2 Montgomery multiplier, result = A*B*2^-N mod M.
module mont_mult_param
    import mont_mult_param_pkg::*;
#(
    parameter int N = 1024,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int K   = calc_k(N, W);
    localparam int KW  = K * W;
    localparam int WCW = K > 1 ? $clog2(K) : 1;
    localparam int IW  = $clog2(N + 1);
    localparam logic [WCW-1:0] WC_LAST = WCW'(K - 1);
    localparam logic [IW-1:0]  I_LAST  = IW'(N - 1);

    state_t         state_q, state_d;
    logic [KW-1:0]  c_q, c_d, b_q, b_d, m_q, m_d;
    logic [N-1:0]   a_q, a_d, result_q, result_d;
    logic [IW-1:0]  i_q, i_d;
    logic [WCW-1:0] wc_q, wc_d;
    logic           carry_q, carry_d, q_q, q_d, busy_q, busy_d, done_q, done_d;
    logic [W-1:0]   op_w, sum;
    logic           sub, cin, cout, word_last;

    // Shift a word in at the top while the bottom word drops out; push(x, x[W-1:0]) rotates.
    function automatic logic [KW-1:0] push(input logic [KW-1:0] x, input logic [W-1:0] wd);
        return (x >> W) | (KW'(wd) << (KW - W));
    endfunction

    assign sub       = state_q == SUB;
    assign word_last = wc_q == WC_LAST;
    assign cin       = wc_q == '0 ? sub : carry_q;
    assign op_w      = state_q == ADD_B ? (b_q[W-1:0] & {W{a_q[0]}}) :
                       state_q == ADD_M ? (m_q[W-1:0] & {W{q_q}}) : m_q[W-1:0];

    mp_addsub_word #(.W(W)) u_addsub (
        .a   (c_q[W-1:0]),
        .b   (op_w),
        .sub (sub),
        .cin (cin),
        .sum (sum),
        .cout(cout)
    );

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        b_d      = b_q;
        m_d      = m_q;
        a_d      = a_q;
        i_d      = i_q;
        wc_d     = wc_q;
        carry_d  = carry_q;
        q_d      = q_q;
        busy_d   = busy_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ADD_B;
                a_d     = in_a;
                b_d     = KW'(in_b);
                m_d     = KW'(in_m);
                c_d     = '0;
                i_d     = '0;
                wc_d    = '0;
                carry_d = 1'b0;
                busy_d  = 1'b1;
            end
            ADD_B, ADD_M, SUB: begin
                wc_d    = word_last ? '0 : wc_q + 1'b1;
                carry_d = cout;
                // The difference goes into b so that C survives for the final select.
                c_d     = sub ? push(c_q, c_q[W-1:0]) : push(c_q, sum);
                b_d     = sub ? push(b_q, sum) : state_q == ADD_B ? push(b_q, b_q[W-1:0]) : b_q;
                m_d     = state_q == ADD_B ? m_q : push(m_q, m_q[W-1:0]);
                q_d     = state_q == ADD_B && wc_q == '0 ? sum[0] : q_q;
                if (word_last)
                    state_d = state_q == ADD_B ? ADD_M : state_q == ADD_M ? SHIFT : SELECT;
            end
            SHIFT: begin
                c_d     = KW'(c_q[N+1:0] >> 1);
                a_d     = a_q >> 1;
                i_d     = i_q + 1'b1;
                state_d = i_q == I_LAST ? SUB : ADD_B;
            end
            SELECT: begin
                result_d = carry_q ? b_q[N-1:0] : c_q[N-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            c_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            i_q      <= '0;
            wc_q     <= '0;
            carry_q  <= 1'b0;
            q_q      <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            b_q      <= b_d;
            m_q      <= m_d;
            a_q      <= a_d;
            i_q      <= i_d;
            wc_q     <= wc_d;
            carry_q  <= carry_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mont_mult_param.sv
// tb_mont_mult_param: scoreboard bench for N=8/W=4 plus a padded-word N=12/W=5 instance.
module tb_mont_mult_param;

    localparam int N = 8, W = 4, LAT = 60;
    localparam int N2 = 12, W2 = 5, LAT2 = 88;
    localparam logic [N-1:0] VA[4] = '{8'h35, 8'hEE, 8'h01, 8'h00};
    localparam logic [N-1:0] VB[4] = '{8'h7A, 8'hEE, 8'h11, 8'h7A};
    localparam logic [N-1:0] VR[4] = '{8'h39, 8'hE1, 8'h01, 8'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, busy, done;
    logic [N-1:0]  in_a, in_b, in_m, result, exp1;
    logic          start2, busy2, done2;
    logic [N2-1:0] a2, b2, m2, result2, exp2;
    int            n_cmp = 0, n_err = 0, done_cnt = 0;
    logic [N-1:0]  sb[$];
    logic [N2-1:0] sb2[$];

    mont_mult_param #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .busy(busy), .result(result), .done(done)
    );

    mont_mult_param #(.N(N2), .W(W2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_a(a2), .in_b(b2), .in_m(m2),
        .busy(busy2), .result(result2), .done(done2)
    );

    // Reference: the x in [0,m) with x*2^n == a*b (mod m), found by search.
    function automatic int unsigned mref(input int unsigned a, input int unsigned b,
                                         input int unsigned m, input int n);
        int unsigned p;
        p = (a * b) % m;
        for (int unsigned x = 0; x < m; x++)
            if (((x << n) % m) == p) return x;
        return 0;
    endfunction

    always @(negedge clk) if (done) begin
        done_cnt++;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra_done: got result=%h, expected no done", result);
        end else begin
            exp1 = sb.pop_front();
            if (result !== exp1) begin
                n_err++;
                $display("FAIL sb_result: got %h, expected %h", result, exp1);
            end
        end
    end

    always @(negedge clk) if (done2) begin
        n_cmp++;
        if (sb2.size() == 0) begin
            n_err++;
            $display("FAIL sb2_extra_done: got result=%h, expected no done", result2);
        end else begin
            exp2 = sb2.pop_front();
            if (result2 !== exp2) begin
                n_err++;
                $display("FAIL sb2_result: got %h, expected %h", result2, exp2);
            end
        end
    end

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input logic [N-1:0] e);
        in_a = a; in_b = b; in_m = m;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start2 = 1'b0;
        in_a = 8'h35; in_b = 8'h7A; in_m = 8'hEF; a2 = '0; b2 = '0; m2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        n_cmp += 5;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, expected 0", done); end
        if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h, expected 00", result); end
        if (busy2 !== 1'b0) begin n_err++; $display("FAIL reset_busy2: got %b, expected 0", busy2); end
        if (result2 !== '0) begin n_err++; $display("FAIL reset_result2: got %h, expected 000", result2); end
        @(posedge clk);
        #1 n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored: busy=%b, expected 0", busy); end
    endtask

    task automatic test_vectors();
        int lat;
        for (int v = 0; v < 4; v++) begin
            launch(VA[v], VB[v], 8'hEF, VR[v]);
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL vec%0d_busy: got %b, expected 1", v, busy); end
            wait_done(lat);
            n_cmp += 2;
            if (lat != LAT) begin n_err++; $display("FAIL vec%0d_latency: got %0d, expected %0d", v, lat, LAT); end
            if (busy !== 1'b0) begin n_err++; $display("FAIL vec%0d_busy_at_done: got %b, expected 0", v, busy); end
            @(posedge clk);
            #1 n_cmp += 2;
            if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_pulse: got %b, expected 0", v, done); end
            if (result !== VR[v]) begin n_err++; $display("FAIL vec%0d_hold: got %h, expected %h", v, result, VR[v]); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, c0;
        launch(8'h35, 8'h7A, 8'hEF, 8'h39);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; in_a = 8'hEE; in_b = 8'hEE;
        @(posedge clk);
        #1 start = 1'b0;
        c0 = done_cnt;
        wait_done(lat);
        repeat (3) @(posedge clk);
        #1 n_cmp += 2;
        if (lat != LAT - 10) begin n_err++; $display("FAIL busy_ignore_latency: got %0d, expected %0d", lat, LAT - 10); end
        if (done_cnt != c0 + 1) begin n_err++; $display("FAIL busy_ignore_done_count: got %0d, expected %0d", done_cnt - c0, 1); end
    endtask

    task automatic test_reset_abort();
        int lat, c0;
        launch(8'hEE, 8'hEE, 8'hEF, 8'hE1);
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        c0 = done_cnt;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        if (result !== '0) begin n_err++; $display("FAIL abort_result: got %h, expected 00", result); end
        repeat (LAT + 5) @(posedge clk);
        #1 n_cmp++;
        if (done_cnt != c0) begin n_err++; $display("FAIL abort_no_done: got %0d dones, expected 0", done_cnt - c0); end
        launch(8'h01, 8'h11, 8'hEF, 8'h01);
        wait_done(lat);
        n_cmp++;
        if (lat != LAT) begin n_err++; $display("FAIL abort_restart_latency: got %0d, expected %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        launch(8'h35, 8'h7A, 8'hEF, 8'h39);
        wait_done(lat1);
        launch(8'h00, 8'h7A, 8'hEF, 8'h00);
        wait_done(lat2);
        n_cmp += 2;
        if (lat1 != LAT) begin n_err++; $display("FAIL b2b_first_latency: got %0d, expected %0d", lat1, LAT); end
        if (lat2 != LAT) begin n_err++; $display("FAIL b2b_second_latency: got %0d, expected %0d", lat2, LAT); end
    endtask

    task automatic test_random();
        int lat;
        int unsigned m, a, b;
        for (int v = 0; v < 60; v++) begin
            m = ($urandom_range(1, 127) << 1) | 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            launch(N'(a), N'(b), N'(m), N'(mref(a, b, m, N)));
            wait_done(lat);
            n_cmp++;
            if (lat != LAT) begin n_err++; $display("FAIL rand%0d_latency: got %0d, expected %0d", v, lat, LAT); end
        end
    endtask

    task automatic test_random_wide();
        int lat;
        int unsigned m, a, b;
        for (int v = 0; v < 30; v++) begin
            m = ($urandom_range(1, 2047) << 1) | 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            a2 = N2'(a); b2 = N2'(b); m2 = N2'(m);
            sb2.push_back(N2'(mref(a, b, m, N2)));
            start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            lat = -1;
            for (int c = 1; c <= LAT2 + 10; c++) begin
                @(posedge clk);
                #1;
                if (done2) begin
                    lat = c;
                    break;
                end
            end
            n_cmp++;
            if (lat != LAT2) begin n_err++; $display("FAIL wide%0d_latency: got %0d, expected %0d", v, lat, LAT2); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_random_wide();
        repeat (3) @(posedge clk);
        #1 n_cmp += 2;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
        if (sb2.size() != 0) begin n_err++; $display("FAIL sb2_leftover: got %0d pending, expected 0", sb2.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
